// File: rtl/registro_descarga_out_if.sv
// rtl/registro_descarga_out_if.sv - result handshake bundle between intermediate stage, unload register and output driver
interface registro_descarga_out_if #(parameter int N = 4);
    logic [N-1:0] res_m;
    logic [3:0]   flags_m;
    logic [1:0]   mode_m;
    logic         valid_m;
    logic         ready_m;
    logic [N-1:0] res_out;
    logic [3:0]   flags_out;
    logic [1:0]   mode_out;
    logic         valid_out;
    logic         ready_out;
    logic         change_out;
    logic [7:0]   count_out;

    modport slave (
        input  res_m, flags_m, mode_m, valid_m, ready_out,
        output ready_m, res_out, flags_out, mode_out, valid_out, change_out, count_out
    );

    modport master (
        output res_m, flags_m, mode_m, valid_m, ready_out,
        input  ready_m, res_out, flags_out, mode_out, valid_out, change_out, count_out
    );
endinterface

// File: rtl/registro_descarga_out.sv
// rtl/registro_descarga_out.sv - two-entry skid unload register with delivery counter and change detect
module registro_descarga_out #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    registro_descarga_out_if.slave bus
);
    localparam int W = N + 6;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   out_q, skid_q, payload_in;
    logic [N-1:0]   last_q, new_res;
    logic           change_q;
    logic [7:0]     count_q;
    logic           in_fire, out_fire;
    logic           ready_int, valid_int;
    logic           load_out_in, load_out_skid, load_skid;

    assign payload_in = {bus.res_m, bus.flags_m, bus.mode_m};

    // Handshake flags come only from the state register, so neither side sees a combinational path.
    assign ready_int = (state != TWO);
    assign valid_int = (state != EMPTY);
    assign in_fire   = bus.valid_m & ready_int;
    assign out_fire  = valid_int & bus.ready_out;

    always_comb begin
        state_nx      = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_out_in = 1'b1;
                    state_nx    = ONE;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    load_skid = 1'b1;
                    state_nx  = TWO;
                end else if (in_fire && out_fire) begin
                    load_out_in = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_out_skid = 1'b1;
                    state_nx      = ONE;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign new_res = load_out_skid ? skid_q[W-1:6] : bus.res_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_q    <= '0;
            skid_q   <= '0;
            last_q   <= '0;
            change_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state <= state_nx;
            if (load_out_in) begin
                out_q <= payload_in;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= payload_in;
            end
            // LAST tracks every OUT load, so the pulse lines up with the first valid cycle of the new result.
            change_q <= 1'b0;
            if (load_out_in || load_out_skid) begin
                change_q <= (new_res != last_q);
                last_q   <= new_res;
            end
            if (out_fire) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    assign bus.ready_m    = ready_int;
    assign bus.valid_out  = valid_int;
    assign bus.res_out    = out_q[W-1:6];
    assign bus.flags_out  = out_q[5:2];
    assign bus.mode_out   = out_q[1:0];
    assign bus.change_out = change_q;
    assign bus.count_out  = count_q;
endmodule

// File: tb/tb_registro_descarga_out.sv
// tb/tb_registro_descarga_out.sv - self-checking bench for registro_descarga_out
module tb_registro_descarga_out;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    registro_descarga_out_if #(.N(4)) bus ();
    registro_descarga_out #(.N(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] res;
        logic [3:0] flags;
        logic [1:0] mode;
        int         id;
    } item_t;

    typedef struct {
        logic       v;
        logic [3:0] res;
        logic [3:0] flags;
        logic [1:0] mode;
        logic       ro;
        logic       e_valid;
        logic [3:0] e_res;
        logic [3:0] e_flags;
        logic [1:0] e_mode;
        logic       e_ready;
        logic       e_change;
        logic [7:0] e_count;
    } vec_t;

    item_t       mq[$];
    int          next_id;
    int          head_id;
    logic [3:0]  last_res;
    int unsigned delivered;
    logic        exp_change;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_id    = 0;
        head_id    = -1;
        last_res   = 4'h0;
        delivered  = 0;
        exp_change = 1'b0;
    endtask

    task automatic drive(logic v, logic [3:0] r, logic [3:0] f, logic [1:0] m, logic ro);
        bus.valid_m   = v;
        bus.res_m     = r;
        bus.flags_m   = f;
        bus.mode_m    = m;
        bus.ready_out = ro;
    endtask

    // One clock of the queue model: a two-deep FIFO whose head is what the consumer sees.
    task automatic tick();
        bit    inf, outf;
        item_t it;
        inf  = bus.valid_m && (mq.size() < 2);
        outf = bus.ready_out && (mq.size() > 0);
        it.res   = bus.res_m;
        it.flags = bus.flags_m;
        it.mode  = bus.mode_m;
        it.id    = next_id;
        @(posedge clk);
        if (outf) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (inf) begin
            mq.push_back(it);
            next_id++;
        end
        exp_change = 1'b0;
        if (mq.size() > 0 && mq[0].id != head_id) begin
            exp_change = (mq[0].res != last_res);
            last_res   = mq[0].res;
            head_id    = mq[0].id;
        end
        @(negedge clk);
    endtask

    task automatic model_check(string tag);
        chk({tag, ".ready_m"}, 32'(bus.ready_m), 32'(mq.size() < 2));
        chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(mq.size() > 0));
        chk({tag, ".change_out"}, 32'(bus.change_out), 32'(exp_change));
        chk({tag, ".count_out"}, 32'(bus.count_out), delivered % 256);
        if (mq.size() > 0) begin
            chk({tag, ".res_out"}, 32'(bus.res_out), 32'(mq[0].res));
            chk({tag, ".flags_out"}, 32'(bus.flags_out), 32'(mq[0].flags));
            chk({tag, ".mode_out"}, 32'(bus.mode_out), 32'(mq[0].mode));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t vt[12];

    initial begin
        model_reset();
        drive(1'b1, 4'hF, 4'hF, 2'b11, 1'b1);

        // Reset held while the source offers data: nothing may be captured.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.res_out", 32'(bus.res_out), 0);
        chk("rst.flags_out", 32'(bus.flags_out), 0);
        chk("rst.mode_out", 32'(bus.mode_out), 0);
        chk("rst.valid_out", 32'(bus.valid_out), 0);
        chk("rst.ready_m", 32'(bus.ready_m), 1);
        chk("rst.change_out", 32'(bus.change_out), 0);
        chk("rst.count_out", 32'(bus.count_out), 0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        tick();
        chk("post_rst.valid_out", 32'(bus.valid_out), 0);
        chk("post_rst.ready_m", 32'(bus.ready_m), 1);

        // Single pass, backpressure 3/7/9, then change detect 6/6/2.
        vt[0]  = '{1'b1, 4'h5, 4'b0000, 2'd2, 1'b1, 1'b1, 4'h5, 4'b0000, 2'd2, 1'b1, 1'b1, 8'd0};
        vt[1]  = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd1};
        vt[2]  = '{1'b1, 4'h3, 4'b1000, 2'd1, 1'b0, 1'b1, 4'h3, 4'b1000, 2'd1, 1'b1, 1'b1, 8'd1};
        vt[3]  = '{1'b1, 4'h7, 4'b0001, 2'd3, 1'b0, 1'b1, 4'h3, 4'b1000, 2'd1, 1'b0, 1'b0, 8'd1};
        vt[4]  = '{1'b1, 4'h9, 4'b0110, 2'd0, 1'b0, 1'b1, 4'h3, 4'b1000, 2'd1, 1'b0, 1'b0, 8'd1};
        vt[5]  = '{1'b1, 4'h9, 4'b0110, 2'd0, 1'b1, 1'b1, 4'h7, 4'b0001, 2'd3, 1'b1, 1'b1, 8'd2};
        vt[6]  = '{1'b1, 4'h9, 4'b0110, 2'd0, 1'b1, 1'b1, 4'h9, 4'b0110, 2'd0, 1'b1, 1'b1, 8'd3};
        vt[7]  = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd4};
        vt[8]  = '{1'b1, 4'h6, 4'b0100, 2'd1, 1'b1, 1'b1, 4'h6, 4'b0100, 2'd1, 1'b1, 1'b1, 8'd4};
        vt[9]  = '{1'b1, 4'h6, 4'b0010, 2'd2, 1'b1, 1'b1, 4'h6, 4'b0010, 2'd2, 1'b1, 1'b0, 8'd5};
        vt[10] = '{1'b1, 4'h2, 4'b0011, 2'd3, 1'b1, 1'b1, 4'h2, 4'b0011, 2'd3, 1'b1, 1'b1, 8'd6};
        vt[11] = '{1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 4'h0, 4'b0000, 2'd0, 1'b1, 1'b0, 8'd7};
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].v, vt[i].res, vt[i].flags, vt[i].mode, vt[i].ro);
            tick();
            chk($sformatf("vec%0d.valid_out", i), 32'(bus.valid_out), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d.ready_m", i), 32'(bus.ready_m), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d.change_out", i), 32'(bus.change_out), 32'(vt[i].e_change));
            chk($sformatf("vec%0d.count_out", i), 32'(bus.count_out), 32'(vt[i].e_count));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d.res_out", i), 32'(bus.res_out), 32'(vt[i].e_res));
                chk($sformatf("vec%0d.flags_out", i), 32'(bus.flags_out), 32'(vt[i].e_flags));
                chk($sformatf("vec%0d.mode_out", i), 32'(bus.mode_out), 32'(vt[i].e_mode));
            end
        end

        // Streaming 0..9 with the consumer always ready.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i), 4'(i), 2'(i), 1'b1);
            tick();
            model_check("stream");
        end
        drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        tick();
        model_check("stream_end");
        chk("stream.count10", 32'(bus.count_out), 10);

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) < 7, 4'($urandom), 4'($urandom), 2'($urandom), ($urandom % 10) < 6);
            tick();
            model_check("rand");
        end

        // Counter wrap after 256 deliveries.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 4'(i), 4'(i >> 4), 2'(i), 1'b1);
            tick();
            model_check("wrap");
        end
        chk("wrap.count_zero", 32'(bus.count_out), 0);

        // Async reset while both registers are full.
        do_reset();
        drive(1'b1, 4'hA, 4'h1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 4'hB, 4'h2, 2'd2, 1'b0);
        tick();
        model_check("fill_two");
        #2 rst = 1'b1;
        #1;
        chk("async_rst.valid_out", 32'(bus.valid_out), 0);
        chk("async_rst.ready_m", 32'(bus.ready_m), 1);
        chk("async_rst.res_out", 32'(bus.res_out), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        tick();
        model_check("after_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/registro_descarga_out.md
# registro_descarga_out

Output unload stage for the Problema2 datapath: the counterpart of the input load register. It accepts each computed result (value, flags, mode tag) from the intermediate stage over a valid/ready handshake. It presents the result to the output side (display/LED driver) on a second valid/ready handshake. A two-entry skid buffer decouples the two sides so neither handshake has a combinational ready path, and the block counts delivered results and flags value changes.

## Interface
- N, 4, width of result value

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- res_m  input  N  result from intermediate stage
- flags_m  input  4  {Neg, Zero, Carry, oVerflow} from intermediate stage
- mode_m  input  2  operation mode tag travelling with result
- valid_m  input  1  intermediate stage has a result this cycle
- ready_m  output  1  block can accept a result this cycle (registered)
- res_out  output  N  delivered result value
- flags_out  output  4  delivered flags
- mode_out  output  2  delivered mode tag
- valid_out  output  1  res_out/flags_out/mode_out hold a valid result
- ready_out  input  1  consumer accepts result this cycle
- change_out  output  1  one-cycle pulse: newly presented result differs in res from previous presented result
- count_out  output  8  number of results delivered (out-side transfers), wraps

## Operation
- Payload = {res, flags, mode}, N+6 bits. Two registers: OUT (drives *_out) and SKID.
- in_fire = valid_m & ready_m; out_fire = valid_out & ready_out.
- FSM states: EMPTY, ONE (OUT full, SKID empty), TWO (both full).
- EMPTY: valid_out=0, ready_m=1. in_fire -> OUT<=payload_in, go ONE.
- ONE: valid_out=1, ready_m=1.
  - in_fire & !out_fire -> SKID<=payload_in, go TWO.
  - in_fire & out_fire -> OUT<=payload_in, stay ONE.
  - !in_fire & out_fire -> go EMPTY.
  - neither -> hold.
- TWO: valid_out=1, ready_m=0 (no in_fire possible). out_fire -> OUT<=SKID, go ONE; else hold.
- Ordering strictly FIFO; no result dropped or duplicated.
- While valid_out=1 & ready_out=0, all *_out bits hold stable.
- change_out: whenever OUT is loaded (from input or SKID), compare new res with LAST register (res of previously loaded OUT, reset 0). If different, change_out=1 the following cycle only. LAST updates on every OUT load.
- count_out: +1 on each out_fire; 255 -> 0 wrap.
- ready_m, valid_out decoded from the registered state only; no combinational path from ready_out to ready_m, nor from valid_m to valid_out.

## Timing
- Reset (async, immediate): state EMPTY, OUT=0, SKID=0, LAST=0, res_out=0, flags_out=0, mode_out=0, valid_out=0, ready_m=1, change_out=0, count_out=0.
- Latency: payload accepted at edge k appears on *_out with valid_out=1 after edge k (1 cycle) when EMPTY or when it directly replaces OUT.
- Throughput: 1 result/cycle sustained with ready_out held high.
- ready_m drops the cycle after SKID fills; returns the cycle after out_fire in TWO.
- change_out asserted in the same cycle the differing result first appears with valid_out=1.
- Reset asserted mid-transfer discards OUT and SKID contents; the first cycle after release is EMPTY with ready_m=1.

## Test plan
- Reset: rst=1 with valid_m=1, res_m=4'hF -> all outputs 0 except ready_m=1; nothing captured.
- Single pass: EMPTY, res_m=4'h5, flags_m=4'b0000, mode_m=2'b10, valid_m 1 cycle, ready_out=1 -> next cycle res_out=5, mode_out=2, valid_out=1, change_out=1; following cycle valid_out=0, count_out=1.
- Backpressure: ready_out=0, send 3, 7, 9 back-to-back -> 3 in OUT, 7 in SKID, ready_m=0, 9 held by source; raise ready_out -> outputs 3, 7, 9 in order on consecutive cycles, count_out=3.
- Streaming: ready_out=1, valid_m=1 for 10 cycles with values 0..9 -> 10 consecutive deliveries, ready_m never drops, count_out=10.
- Change detect: deliver 6, 6, 2 -> change_out pulses for first 6 and for 2, not for second 6.
- Wrap: 256 deliveries -> count_out returns to 0; async reset pulse while in TWO -> immediately EMPTY, valid_out=0.
